seq_modulo: RTL and testbench
=============================

Name: seq_modulo

Overview:
- Parametrised, handshaked, iterative modulo/division unit; the generalised successor to the fixed mod-14 reducer.
- Computes remainder and quotient of an unsigned WIDTH-bit dividend by a runtime WIDTH-bit divisor, using restoring division with one quotient bit per cycle.
- Sits between I/O register stages in the NN datapath, for index wrapping and bucket reduction.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  unit can accept an operand pair
dividend  input  WIDTH  unsigned dividend
divisor  input  WIDTH  unsigned divisor (modulus)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
remainder  output  WIDTH  dividend mod divisor
quotient  output  WIDTH  dividend / divisor
div_by_zero  output  1  result came from divisor == 0

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; in_ready=0 while reset_n is low, then 1 in IDLE; out_valid=0; remainder=0; quotient=0; div_by_zero=0; counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: latch dividend into shift register Q, divisor into D; clear partial remainder R (WIDTH+1 bits); counter=WIDTH-1; set div_by_zero=(divisor==0); go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: T={R[WIDTH-1:0],Q[WIDTH-1]}. If T>={1'b0,D}, then R=T-D and the new Q LSB is 1; else R=T and the new Q LSB is 0. Q shifts left by one.
  - Counter decrements; at counter==0 the step completes and the state goes to DONE.
- DONE:
  - out_valid=1; remainder=R[WIDTH-1:0]; quotient=Q; both are held stable.
  - On out_valid&&out_ready: go to IDLE with out_valid=0 on the next edge.
- Latency: accept at edge k, out_valid high after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- Back-pressure: with out_ready low, DONE holds indefinitely; results, div_by_zero and in_ready=0 stay unchanged.
- divisor==0: no special path. The restoring algorithm naturally yields quotient = all ones and remainder = dividend; div_by_zero=1. Latency is the same.
- dividend < divisor: quotient=0, remainder=dividend.
- divisor==1: remainder=0, quotient=dividend.
- Operand inputs are ignored outside the accept edge; changes during CALC have no effect.
- No new accept is possible in DONE, even if out_ready and in_valid are asserted together. in_ready rises the cycle after the handshake.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. No output pulse is produced; the unit returns to the reset values above.
- Width rules:
  - Compare/subtract is done at WIDTH+1 bits, so there is no overflow for divisor > 2^(WIDTH-1).
  - All arithmetic is unsigned.
  - The remainder is always < divisor when divisor != 0.

Decomposition:
- Package seq_modulo_pkg:
  - state enum type (IDLE, CALC, DONE);
  - localparam function for CNT_W.
- Sub-module mod_step (combinational, parametrised WIDTH):
  - inputs: R, Q MSB, D;
  - outputs: next R, quotient bit.
  - One restoring-division step; instantiated once and also reusable for a future unrolled/pipelined variant.

Test Plan:
- WIDTH=8, dividend=200, divisor=14, out_ready=1 -> out_valid exactly 8 cycles after accept; remainder=4, quotient=14, div_by_zero=0.
- dividend=13, divisor=14 -> remainder=13, quotient=0. dividend=255, divisor=1 -> remainder=0, quotient=255. dividend=255, divisor=255 -> remainder=0, quotient=1.
- dividend=77, divisor=0 -> remainder=77, quotient=255, div_by_zero=1, same latency.
- Back-pressure: out_ready low for 20 cycles after out_valid -> outputs stable, in_ready=0; out_ready pulse -> out_valid drops next edge, in_ready=1.
- in_valid held high with changing operands during CALC -> only the first pair is processed. Back-to-back ops with 100%14=2 then 250%7=5 give correct results in order.
- reset_n pulsed low mid-CALC (cycle 4) -> out_valid stays 0, in_ready=1 after release; the next op, 50%6, gives remainder=2, quotient=8.
- Randomised self-check (1000 pairs including divisor=0) against reference % and / -> zero mismatches.

Source files
------------

// File: rtl/seq_modulo_pkg.sv
// Shared types and derived widths for the iterative modulo/division unit.
package seq_modulo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_modulo_mod_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and emit the resulting quotient bit.
module mod_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d_ext;
    logic           unused_r_msb;

    // R stays below D between steps, so its top bit never carries information.
    assign unused_r_msb = r[WIDTH];
    assign t            = {r[WIDTH-1:0], q_msb};
    assign d_ext        = {1'b0, d};

    always_comb begin
        q_bit  = 1'b0;
        r_next = t;
        if (t >= d_ext) begin
            q_bit  = 1'b1;
            r_next = t - d_ext;
        end
    end

endmodule

// File: rtl/seq_modulo.sv
// Handshaked iterative unsigned divider: one quotient bit per cycle, result
// held in DONE until the consumer takes it.
module seq_modulo
    import seq_modulo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH:0]   r_q, r_nx;
    logic [WIDTH-1:0] q_q, d_q;
    logic [CNT_W-1:0] cnt;
    logic             dbz_q;
    logic             q_bit;
    logic             accept;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (r_nx),
        .q_bit  (q_bit)
    );

    // in_ready is gated by reset_n so it reads low for the whole reset window.
    assign in_ready    = reset_n && (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign remainder   = r_q[WIDTH-1:0];
    assign quotient    = q_q;
    assign div_by_zero = dbz_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)      state_nx = CALC;
            CALC:    if (cnt == '0)   state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            r_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt   <= CNT_W'(WIDTH - 1);
            dbz_q <= (divisor == '0);
        end else if (state == CALC) begin
            r_q <= r_nx;
            q_q <= {q_q[WIDTH-2:0], q_bit};
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_modulo.sv
// Randomised and directed self-check of seq_modulo against plain / and %.
module tb_seq_modulo;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] remainder;
    logic [W-1:0] quotient;
    logic         div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    seq_modulo #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .remainder   (remainder),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_quo(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(a % b);
    endfunction

    // Wait for out_valid after an accept edge; returns edges elapsed.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    // Called 1 time unit after a rising edge with the unit idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int lat;
        chk({tag, "_in_ready"}, in_ready, 1);
        dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        dividend = $urandom; divisor = $urandom;
        wait_done(lat);
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_rem"}, remainder, ref_rem(a, b));
        chk({tag, "_quo"}, quotient, ref_quo(a, b));
        chk({tag, "_dbz"}, div_by_zero, (b == 0));
        if (out_ready) begin
            @(posedge clock); #1;
            chk({tag, "_drop"}, out_valid, 0);
            chk({tag, "_rdy_back"}, in_ready, 1);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] hr, hq;

        // Reset values
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_quo", quotient, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_in_ready", in_ready, 1);

        // Directed cases
        run_op(8'd200, 8'd14, "d200_14");
        run_op(8'd13, 8'd14, "d13_14");
        run_op(8'd255, 8'd1, "d255_1");
        run_op(8'd255, 8'd255, "d255_255");
        run_op(8'd77, 8'd0, "d77_0");
        run_op(8'd0, 8'd200, "d0_200");
        run_op(8'd129, 8'd130, "d129_130");

        // Back-pressure: result must hold for 20 cycles
        out_ready = 1'b0;
        run_op(8'd91, 8'd9, "bp");
        hr = remainder; hq = quotient;
        repeat (20) begin
            @(posedge clock); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_rem_hold", remainder, 8'd1);
            chk("bp_quo_hold", quotient, 8'd10);
        end
        in_valid = 1'b1; dividend = 8'd9; divisor = 8'd2;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_no_accept_in_done", (remainder == hr) && (quotient == hq), 1);

        // in_valid held high with churning operands, then back-to-back
        dividend = 8'd100; divisor = 8'd14; in_valid = 1'b1;
        @(posedge clock); #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            dividend = $urandom; divisor = $urandom;
            @(posedge clock); #1;
            lat++;
        end
        chk("b2b1_latency", lat, W);
        chk("b2b1_rem", remainder, 8'd2);
        chk("b2b1_quo", quotient, 8'd7);
        dividend = 8'd250; divisor = 8'd7;
        @(posedge clock); #1;
        chk("b2b_gap_ready", in_ready, 1);
        chk("b2b_gap_valid", out_valid, 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_done(lat);
        chk("b2b2_latency", lat, W);
        chk("b2b2_rem", remainder, 8'd5);
        chk("b2b2_quo", quotient, 8'd35);
        @(posedge clock); #1;

        // Reset mid-CALC aborts without a result pulse
        dividend = 8'd123; divisor = 8'd5; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_rem", remainder, 0);
        chk("abort_quo", quotient, 0);
        @(negedge clock); reset_n = 1'b1;
        lat = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_valid) lat++;
        end
        chk("abort_no_pulse", lat, 0);
        run_op(8'd50, 8'd6, "post_abort");

        // Randomised sweep
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 3));
                2:       b = W'($urandom_range(128, 255));
                default: b = W'($urandom);
            endcase
            run_op(a, b, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule
